// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter that shares the Hyperbus FIFO command port between NPORTS requesters.
// Define HYPERBUS_ARB_PRIORITY_EN to select fixed lowest-index-first priority.
module hyperbus_arbiter #(
    parameter int NPORTS          = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORTS-1:0]            req,
    input  logic [NPORTS-1:0]            we,
    input  logic [NPORTS*ADDR_WIDTH-1:0] adr,
    input  logic [NPORTS*DATA_WIDTH-1:0] wdat,
    output logic [NPORTS-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]        rdat,
    output logic [NPORTS-1:0]            rvalid,
    output logic [NPORTS-1:0]            wack,
    output logic                         rrq,
    output logic                         wrq,
    output logic [ADDR_WIDTH-1:0]        adr_o,
    output logic [DATA_WIDTH-1:0]        tx_dat_o,
    input  logic [DATA_WIDTH-1:0]        rx_dat_i,
    input  logic                         rx_valid,
    input  logic                         tx_ready,
    output logic                         err
);

    localparam int TAG_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic [NPORTS-1:0]       gnt_q;
    logic [NPORTS-1:0]       rvalid_q;
    logic [NPORTS-1:0]       wack_q;
    logic                    rrq_q;
    logic                    wrq_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   txd_q;
    logic [DATA_WIDTH-1:0]   rdat_q;

    logic                    issue;
    logic [TAG_W-1:0]        win;
    logic                    win_we;

`ifndef HYPERBUS_ARB_PRIORITY_EN
    logic [TAG_W-1:0]        ptr_q;
    int                      rr_idx;
`endif

    // Index 0 = read tag queue, index 1 = write tag queue.
    logic [1:0]              push;
    logic [1:0]              pop;
    logic [1:0]              resp;
    logic [1:0]              q_empty;
    logic [1:0][TAG_W-1:0]   q_head;

    always_comb begin
        issue = 1'b0;
        win   = '0;
`ifndef HYPERBUS_ARB_PRIORITY_EN
        rr_idx = 0;
`endif
        if (state_q == IDLE && count_q < CNT_W'(MAX_OUTSTANDING)) begin
`ifdef HYPERBUS_ARB_PRIORITY_EN
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    issue = 1'b1;
                    win   = TAG_W'(i);
                end
            end
`else
            // Walk the search order backwards so the port nearest after ptr_q wins last.
            for (int i = NPORTS; i >= 1; i--) begin
                rr_idx = int'(ptr_q) + i;
                if (rr_idx >= NPORTS) rr_idx = rr_idx - NPORTS;
                if (req[rr_idx]) begin
                    issue = 1'b1;
                    win   = TAG_W'(rr_idx);
                end
            end
`endif
        end
    end

    assign win_we  = we[win];
    assign push[0] = issue & ~win_we;
    assign push[1] = issue & win_we;
    assign resp    = {tx_ready, rx_valid};
    assign pop     = resp & ~q_empty;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tagq
            logic [TAG_W-1:0] mem [MAX_OUTSTANDING];
            logic [PTR_W-1:0] wr_q;
            logic [PTR_W-1:0] rd_q;
            logic [CNT_W-1:0] fill_q;

            always_ff @(posedge clk) begin
                if (push[gi]) mem[wr_q] <= win;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_q   <= '0;
                    rd_q   <= '0;
                    fill_q <= '0;
                end else begin
                    if (push[gi])
                        wr_q <= (wr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
                    if (pop[gi])
                        rd_q <= (rd_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
                    fill_q <= fill_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
                end
            end

            assign q_empty[gi] = (fill_q == '0);
            assign q_head[gi]  = mem[rd_q];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            wack_q   <= '0;
            rrq_q    <= 1'b0;
            wrq_q    <= 1'b0;
            err_q    <= 1'b0;
            adr_q    <= '0;
            txd_q    <= '0;
            rdat_q   <= '0;
`ifndef HYPERBUS_ARB_PRIORITY_EN
            ptr_q    <= TAG_W'(NPORTS - 1);
`endif
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            wack_q   <= '0;
            rrq_q    <= 1'b0;
            wrq_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        gnt_q   <= NPORTS'(1) << win;
                        rrq_q   <= ~win_we;
                        wrq_q   <= win_we;
                        adr_q   <= adr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        txd_q   <= wdat[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                        state_q <= ISSUE;
`ifndef HYPERBUS_ARB_PRIORITY_EN
                        ptr_q   <= win;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (pop[0]) begin
                rvalid_q <= NPORTS'(1) << q_head[0];
                rdat_q   <= rx_dat_i;
            end
            if (pop[1]) wack_q <= NPORTS'(1) << q_head[1];
            // Orphan responses are dropped; the count only tracks tagged transactions.
            if ((resp & q_empty) != 2'b00) err_q <= 1'b1;
            count_q <= count_q + CNT_W'(issue) - CNT_W'(pop[0]) - CNT_W'(pop[1]);
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign wack     = wack_q;
    assign rrq      = rrq_q;
    assign wrq      = wrq_q;
    assign err      = err_q;
    assign adr_o    = adr_q;
    assign tx_dat_o = txd_q;
    assign rdat     = rdat_q;

endmodule
